// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states, instruction field helpers.
// No logic of its own; imported by the sequencer.
// Instruction byte layout: OPC=[7:4], RA=[3:2], RB=[1:0].
package alu_sequencer_pkg;

    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_J   = 4'h8;
    localparam logic [3:0] OP_JAL = 4'h9;
    localparam logic [3:0] OP_LW  = 4'hA;
    localparam logic [3:0] OP_SW  = 4'hB;
    localparam logic [3:0] OP_BEQ = 4'hC;
    localparam logic [3:0] OP_BNE = 4'hD;
    localparam logic [3:0] OP_NOT = 4'hE;
    localparam logic [3:0] OP_LI  = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    function automatic logic [3:0] f_opc(input logic [7:0] instr);
        return instr[7:4];
    endfunction

    function automatic logic [1:0] f_ra(input logic [7:0] instr);
        return instr[3:2];
    endfunction

    function automatic logic [1:0] f_rb(input logic [7:0] instr);
        return instr[1:0];
    endfunction

    // Sign-extend the 2-bit branch displacement held in the RB field
    function automatic logic [7:0] f_sext2(input logic [1:0] imm);
        return {{6{imm[1]}}, imm};
    endfunction

    // Opcodes whose ALU result lands in R[RA]
    function automatic logic f_writes_alu(input logic [3:0] opc);
        logic w;
        case (opc)
            OP_MOV, OP_ADD, OP_SUB, OP_AND,
            OP_OR,  OP_XOR, OP_SHL, OP_SHR,
            OP_NOT, OP_LI:               w = 1'b1;
            default:                     w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM sequencing fetch, register read, ALU, data memory and write-back.
// 4 cycles per non-memory instruction, 5 for LW/SW, plus one per memory wait cycle.
// Memory requests are held until ack; run is sampled only in IDLE and at the end of WB.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00,
    parameter logic [1:0] LINK_REG = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic       imem_req,
    output logic [7:0] imem_addr,
    input  logic       imem_ack,
    input  logic [7:0] imem_rdata,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic [7:0] dmem_addr,
    output logic [7:0] dmem_wdata,
    input  logic       dmem_ack,
    input  logic [7:0] dmem_rdata,
    output logic [1:0] rf_ra0,
    output logic [1:0] rf_ra1,
    input  logic [7:0] rf_rd0,
    input  logic [7:0] rf_rd1,
    output logic       rf_we,
    output logic [1:0] rf_wa,
    output logic [7:0] rf_wdata,
    output logic [7:0] alu_instr,
    output logic [7:0] alu_in0,
    output logic [7:0] alu_in1,
    output logic [7:0] alu_pc,
    input  logic [7:0] alu_out,
    input  logic [7:0] alu_jump,
    input  logic       alu_ovf,
    output logic [7:0] pc,
    output logic       busy,
    output logic       ovf_sticky
);

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic [7:0] r_in0;
    logic [7:0] r_in1;
    logic [7:0] r_alu_instr;
    logic       r_imem_req;
    logic       r_dmem_req;
    logic       r_dmem_we;
    logic       r_rf_we;
    logic [1:0] r_rf_wa;
    logic [7:0] r_rf_wdata;
    logic       r_ovf;

    logic [3:0] w_opc;
    logic       w_is_jump;
    logic       w_is_mem;
    logic       w_taken;
    logic [7:0] w_pc_inc;
    logic [7:0] w_next_pc;

    assign w_opc     = f_opc(r_ir);
    assign w_is_jump = (w_opc == OP_J) || (w_opc == OP_JAL);
    assign w_is_mem  = (w_opc == OP_LW) || (w_opc == OP_SW);
    assign w_taken   = ((w_opc == OP_BEQ) || (w_opc == OP_BNE)) && (alu_jump != 8'd0);
    assign w_pc_inc  = r_pc + 8'd1;

    // PC after WB; ALU inputs are stable through WB so alu_out/alu_jump are valid here
    always_comb begin
        w_next_pc = w_pc_inc;
        if (w_is_jump) begin
            w_next_pc = w_pc_inc + alu_out;
        end else if (w_taken) begin
            w_next_pc = w_pc_inc + f_sext2(f_rb(r_ir));
        end
    end

    // Instruction sequencing FSM; all bus/strobe outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= PC_RESET;
            r_ir        <= 8'd0;
            r_in0       <= 8'd0;
            r_in1       <= 8'd0;
            r_alu_instr <= 8'd0;
            r_imem_req  <= 1'b0;
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_rf_we     <= 1'b0;
            r_rf_wa     <= 2'd0;
            r_rf_wdata  <= 8'd0;
            r_ovf       <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse covering exactly the WB cycle
            r_rf_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (r_imem_req && imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_in0       <= rf_rd0;
                    r_in1       <= rf_rd1;
                    r_alu_instr <= r_ir;
                    r_state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (w_is_mem) begin
                        r_state    <= ST_MEM;
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= (w_opc == OP_SW);
                    end else begin
                        r_state    <= ST_WB;
                        r_rf_we    <= f_writes_alu(w_opc) || (w_opc == OP_JAL);
                        r_rf_wa    <= (w_opc == OP_JAL) ? LINK_REG : f_ra(r_ir);
                        r_rf_wdata <= (w_opc == OP_JAL) ? w_pc_inc : alu_out;
                    end
                end
                ST_MEM: begin
                    if (r_dmem_req && dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_state    <= ST_WB;
                        if (w_opc == OP_LW) begin
                            r_rf_we    <= 1'b1;
                            r_rf_wa    <= f_ra(r_ir);
                            r_rf_wdata <= dmem_rdata;
                        end
                    end
                end
                ST_WB: begin
                    r_pc <= w_next_pc;
                    if ((w_opc == OP_ADD) && alu_ovf) begin
                        r_ovf <= 1'b1;
                    end
                    if (run) begin
                        r_state    <= ST_FETCH;
                        r_imem_req <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_in1;
    assign dmem_wdata = r_in0;
    assign rf_ra0     = f_ra(r_ir);
    assign rf_ra1     = f_rb(r_ir);
    assign rf_we      = r_rf_we;
    assign rf_wa      = r_rf_wa;
    assign rf_wdata   = r_rf_wdata;
    assign alu_instr  = r_alu_instr;
    assign alu_in0    = r_in0;
    assign alu_in1    = r_in1;
    assign alu_pc     = r_pc;
    assign pc         = r_pc;
    assign busy       = (r_state != ST_IDLE);
    assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: environment models (memories, register file, ALU) plus an
// instruction-level reference model; directed scenarios first, then random programs.
// Each instruction is checked for cycle count, pc, registers, sticky overflow and side effects.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       imem_req, imem_ack;
    logic [7:0] imem_addr, imem_rdata;
    logic       dmem_req, dmem_we, dmem_ack;
    logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [1:0] rf_ra0, rf_ra1, rf_wa;
    logic [7:0] rf_rd0, rf_rd1, rf_wdata;
    logic       rf_we;
    logic [7:0] alu_instr, alu_in0, alu_in1, alu_pc, alu_out, alu_jump;
    logic       alu_ovf;
    logic [7:0] pc;
    logic       busy, ovf_sticky;

    alu_sequencer #(.PC_RESET(8'h00), .LINK_REG(2'd3)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wdata(rf_wdata),
        .alu_instr(alu_instr), .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_pc(alu_pc),
        .alu_out(alu_out), .alu_jump(alu_jump), .alu_ovf(alu_ovf),
        .pc(pc), .busy(busy), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    // ---------------- environment ----------------
    logic [7:0] imem [256];
    logic [7:0] dmem [256];
    logic [7:0] regs [4];
    int imem_wait = 0, dmem_wait = 0;
    int icnt, dcnt;
    int we_cnt = 0, st_cnt = 0, dreq_cnt = 0;
    logic [7:0] st_addr, st_data;
    logic       pl_en = 1'b0;
    logic [1:0] pl_a = 2'd0;
    logic [7:0] pl_d = 8'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt <= 0;
            dcnt <= 0;
        end else begin
            icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
            dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        end
    end

    assign imem_ack   = imem_req && (icnt == imem_wait);
    assign imem_rdata = imem[imem_addr];
    assign dmem_ack   = dmem_req && (dcnt == dmem_wait);
    assign dmem_rdata = dmem[dmem_addr];
    assign rf_rd0     = regs[rf_ra0];
    assign rf_rd1     = regs[rf_ra1];

    always @(posedge clk) begin
        if (rf_we) begin
            regs[rf_wa] <= rf_wdata;
            we_cnt      <= we_cnt + 1;
        end else if (pl_en) begin
            regs[pl_a] <= pl_d;
        end
        if (dmem_req) dreq_cnt <= dreq_cnt + 1;
        if (dmem_req && dmem_ack && dmem_we) begin
            st_cnt  <= st_cnt + 1;
            st_addr <= dmem_addr;
            st_data <= dmem_wdata;
        end
    end

    // Combinational ALU: jump targets come out relative to pc+1; alu_jump acts as a zero flag
    function automatic logic [7:0] alu_res(input logic [7:0] ins, input logic [7:0] x,
                                           input logic [7:0] y, input logic [7:0] p);
        logic [7:0] r;
        case (ins[7:4])
            4'h0:       r = y;
            4'h1:       r = x + y;
            4'h2:       r = x - y;
            4'h3:       r = x & y;
            4'h4:       r = x | y;
            4'h5:       r = x ^ y;
            4'h6:       r = x << 1;
            4'h7:       r = x >> 1;
            4'h8, 4'h9: r = y - p - 8'd1;
            4'hE:       r = ~x;
            4'hF:       r = {6'd0, ins[1:0]};
            default:    r = 8'd0;
        endcase
        return r;
    endfunction

    logic [7:0] w_sum, w_dif;
    assign w_sum    = alu_in0 + alu_in1;
    assign w_dif    = alu_in0 - alu_in1;
    assign alu_out  = alu_res(alu_instr, alu_in0, alu_in1, alu_pc);
    assign alu_jump = (alu_instr[7:4] == 4'hD) ? {7'd0, alu_in0 != alu_in1}
                                               : {7'd0, alu_in0 == alu_in1};
    assign alu_ovf  = (alu_instr[7:4] == 4'h1) ? ((alu_in0[7] == alu_in1[7]) && (w_sum[7] != alu_in0[7])) :
                      (alu_instr[7:4] == 4'h2) ? ((alu_in0[7] != alu_in1[7]) && (w_dif[7] != alu_in0[7])) :
                      1'b0;

    // ---------------- reference model and checking ----------------
    int n_pass = 0, n_total = 0;
    int m_regs [4];
    int m_pc = 0;
    int m_ovf = 0;
    int last_n = 0, last_dq = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_reg(input logic [1:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
        m_regs[a] = int'(d);
    endtask

    task automatic start_run();
        run = 1'b1;
        @(posedge clk); #1;
        chk("start_fetch", 32'(imem_req), 32'(1));
    endtask

    // Called one step after fetch has begun; runs one instruction and compares with the model
    task automatic do_instr(input int iw, input int dw, input bit stop);
        logic [7:0] ins;
        logic [3:0] opc;
        logic [1:0] a, b;
        int x, y, npc, sx, sy, s, exp_cyc, exp_we, exp_st, we0, st0, dq0, n;
        bit done, prev;
        ins = imem[m_pc[7:0]];
        opc = ins[7:4]; a = ins[3:2]; b = ins[1:0];
        x = m_regs[a]; y = m_regs[b];
        npc = (m_pc + 1) & 255;
        exp_we = 0; exp_st = 0;
        case (opc)
            4'h1: begin
                m_regs[a] = (x + y) & 255;
                sx = (x > 127) ? x - 256 : x;
                sy = (y > 127) ? y - 256 : y;
                s  = sx + sy;
                if (s > 127 || s < -128) m_ovf = 1;
                exp_we = 1;
            end
            4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE, 4'hF: begin
                m_regs[a] = int'(alu_res(ins, 8'(x), 8'(y), 8'(m_pc)));
                exp_we = 1;
            end
            4'hA: begin m_regs[a] = int'(dmem[y[7:0]]); exp_we = 1; end
            4'hB: exp_st = 1;
            4'h8: npc = y;
            4'h9: begin m_regs[3] = (m_pc + 1) & 255; npc = y; exp_we = 1; end
            4'hC: if (x == y) npc = (m_pc + 1 + ((b >= 2'd2) ? int'(b) - 4 : int'(b))) & 255;
            4'hD: if (x != y) npc = (m_pc + 1 + ((b >= 2'd2) ? int'(b) - 4 : int'(b))) & 255;
            default: ;
        endcase
        m_pc = npc;
        exp_cyc = 4 + iw + ((opc == 4'hA || opc == 4'hB) ? 1 + dw : 0);

        imem_wait = iw; dmem_wait = dw;
        if (stop) run = 1'b0;
        we0 = we_cnt; st0 = st_cnt; dq0 = dreq_cnt;
        n = 0; done = 1'b0; prev = 1'b1;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (!busy || (imem_req && !prev)) done = 1'b1;
            prev = imem_req;
        end
        chk("instr_done", 32'(done), 32'(1));
        chk("cycles", 32'(n), 32'(exp_cyc));
        chk("busy_after", 32'(busy), 32'(!stop));
        chk("pc", 32'(pc), 32'(m_pc));
        for (int k = 0; k < 4; k++) chk($sformatf("reg%0d", k), 32'(regs[k]), 32'(m_regs[k]));
        chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
        chk("rf_we_pulses", 32'(we_cnt - we0), 32'(exp_we));
        chk("store_count", 32'(st_cnt - st0), 32'(exp_st));
        if (exp_st == 1) begin
            chk("store_addr", 32'(st_addr), 32'(y));
            chk("store_data", 32'(st_data), 32'(x));
        end
        last_n = n;
        last_dq = dreq_cnt - dq0;
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) begin imem[i] = 8'h00; dmem[i] = 8'h00; end
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        rst_n = 1'b0;
        run   = 1'b1;
        // regs start as X; give them known values while the DUT sits in reset
        set_reg(2'd0, 8'h00); set_reg(2'd2, 8'h00);
        set_reg(2'd3, 8'h05); set_reg(2'd1, 8'h07);
        imem[0] = 8'h1D;
        chk("rst_pc", 32'(pc), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_imem_req", 32'(imem_req), 32'(0));
        chk("rst_dmem_req", 32'(dmem_req), 32'(0));
        chk("rst_rf_we", 32'(rf_we), 32'(0));
        chk("rst_alu_instr", 32'(alu_instr), 32'(0));
        chk("rst_ovf", 32'(ovf_sticky), 32'(0));

        // 1: ADD R3,R1 straight out of reset
        rst_n = 1'b1;
        start_run();
        do_instr(0, 0, 1'b1);
        chk("t1_r3", 32'(regs[3]), 32'(12));
        chk("t1_pc", 32'(pc), 32'(1));
        chk("t1_cycles", 32'(last_n), 32'(4));

        // 2: signed overflow sets the sticky flag, which survives the next instruction
        set_reg(2'd3, 8'h7F); set_reg(2'd1, 8'h01);
        imem[1] = 8'h1D; imem[2] = 8'h01;
        start_run();
        do_instr(0, 0, 1'b0);
        chk("t2_r3", 32'(regs[3]), 32'(8'h80));
        chk("t2_ovf", 32'(ovf_sticky), 32'(1));
        do_instr(0, 0, 1'b1);
        chk("t2_ovf_held", 32'(ovf_sticky), 32'(1));

        // 3: LW with three wait cycles
        set_reg(2'd0, 8'h30);
        dmem[8'h30] = 8'hA5;
        imem[3] = 8'hA8;
        start_run();
        do_instr(0, 3, 1'b1);
        chk("t3_r2", 32'(regs[2]), 32'(8'hA5));
        chk("t3_dreq_cycles", 32'(last_dq), 32'(4));
        chk("t3_cycles", 32'(last_n), 32'(8));

        // 4: BEQ at the top of the address space, taken and not taken
        set_reg(2'd1, 8'hFF);
        imem[4] = 8'h81;
        start_run();
        do_instr(0, 0, 1'b1);
        chk("t4_jump_ff", 32'(pc), 32'(8'hFF));
        imem[8'hFF] = 8'hCF;
        start_run();
        do_instr(0, 0, 1'b1);
        chk("t4_beq_taken", 32'(pc), 32'(8'hFF));
        imem[8'hFF] = 8'hC3;
        set_reg(2'd0, 8'h01); set_reg(2'd3, 8'h02);
        start_run();
        do_instr(0, 0, 1'b1);
        chk("t4_beq_not_taken", 32'(pc), 32'(8'h00));

        // 5: JAL from 0x10 to 0x40
        imem[0] = 8'h81;
        set_reg(2'd1, 8'h10);
        start_run();
        do_instr(0, 0, 1'b1);
        set_reg(2'd1, 8'h40);
        imem[8'h10] = 8'h91;
        start_run();
        do_instr(0, 0, 1'b1);
        chk("t5_pc", 32'(pc), 32'(8'h40));
        chk("t5_link", 32'(regs[3]), 32'(8'h11));

        // 6: reset during a data-memory stall
        imem[8'h40] = 8'hA8;
        imem_wait = 0; dmem_wait = 20;
        start_run();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (dmem_req) seen = 1'b1;
        end
        chk("t6_in_mem", 32'(seen), 32'(1));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #2;
        chk("t6_dmem_req", 32'(dmem_req), 32'(0));
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_pc", 32'(pc), 32'(0));
        chk("t6_ovf", 32'(ovf_sticky), 32'(0));
        run = 1'b0; dmem_wait = 0;
        #2 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_idle_busy", 32'(busy), 32'(0));
        chk("t6_idle_imem_req", 32'(imem_req), 32'(0));
        m_pc = 0; m_ovf = 0;

        // Random programs with random memory latency
        for (int i = 0; i < 256; i++) begin
            imem[i] = 8'($urandom);
            dmem[i] = 8'($urandom);
        end
        for (int r = 0; r < 4; r++) set_reg(2'(r), 8'($urandom));
        start_run();
        for (int t = 0; t < 200; t++) begin
            bit stop;
            stop = ($urandom_range(0, 7) == 0) || (t == 199);
            do_instr($urandom_range(0, 2), $urandom_range(0, 3), stop);
            if (stop && t != 199) start_run();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
